// File: rtl/accel_pkg.sv
// Shared constants and state encodings for the ADXL345 SPI sampler.
// Holds register addresses, command bits, init payloads and transfer lengths.
package accel_pkg;

  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] SPI_RD = 8'h80;
  localparam logic [7:0] SPI_MB = 8'h40;

  localparam logic [7:0] DATA_FORMAT_VAL = 8'h00;
  localparam logic [7:0] POWER_CTL_VAL   = 8'h08;

  localparam logic [7:0] CMD_READ_XY = SPI_RD | SPI_MB | REG_DATAX0;

  localparam logic [5:0] LEN_WRITE = 6'd16;
  localparam logic [5:0] LEN_READ  = 6'd40;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT_FMT,
    ST_INIT_PWR,
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_LEAD,
    SH_LOW,
    SH_HIGH,
    SH_GAP
  } shift_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/accel_spi_shift.sv
// Generic SPI mode-3 shifter (up to 40 bits): MSB-first tx, last 32 rx bits kept.
// finish is combinational and marks the clk edge on which cs_n rises.
module accel_spi_shift
  import accel_pkg::*;
#(
  parameter int SCLK_HALF = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [39:0] tx,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        ready,
  output logic        finish,
  output logic [31:0] rx
);

  shift_state_t state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [5:0]   bits_q, bits_d;
  logic [39:0]  shreg_q, shreg_d;
  logic [31:0]  rx_q, rx_d;
  logic         cs_n_q, cs_n_d;
  logic         sclk_q, sclk_d;
  logic         mosi_q, mosi_d;
  logic         half_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SH_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    bits_d   = bits_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    finish   = 1'b0;
    half_end = (cnt_q == 32'(SCLK_HALF - 1));
    case (state_q)
      SH_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SH_LEAD;
          cs_n_d  = 1'b0;
          shreg_d = tx;
          bits_d  = len;
        end
      end
      SH_LEAD: begin
        if (half_end) begin
          state_d = SH_LOW;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = shreg_q[39];
          shreg_d = {shreg_q[38:0], 1'b0};
        end
      end
      SH_LOW: begin
        if (half_end) begin
          state_d = SH_HIGH;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], miso};
          bits_d  = bits_q - 6'd1;
        end
      end
      SH_HIGH: begin
        if (half_end) begin
          cnt_d = '0;
          // The final high half doubles as the cs_n trailing delay.
          if (bits_q == 6'd0) begin
            state_d = SH_GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            finish  = 1'b1;
          end else begin
            state_d = SH_LOW;
            sclk_d  = 1'b0;
            mosi_d  = shreg_q[39];
            shreg_d = {shreg_q[38:0], 1'b0};
          end
        end
      end
      SH_GAP: begin
        if (cnt_q == 32'(2 * SCLK_HALF - 1)) begin
          state_d = SH_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  assign ready = (state_q == SH_IDLE);
  assign cs_n  = cs_n_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign rx    = rx_q;

endmodule

// File: rtl/accel_spi_sampler.sv
// ADXL345 poller: optional init writes, fixed-rate X/Y burst reads, sign-extended outputs.
// Define ACCEL_INIT_EN to run the DATA_FORMAT/POWER_CTL writes after reset.
module accel_spi_sampler
  import accel_pkg::*;
#(
  parameter int SCLK_HALF  = 25,
  parameter int SAMPLE_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        sample_tick,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic        busy,
  output logic        overrun,
  output logic        init_done
);

  state_t      state_q, state_d;
  logic        launched_q, launched_d;
  logic        init_done_q, init_done_d;
  logic        overrun_q, overrun_d;
  logic [31:0] rate_q, rate_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        req;
  logic        shift_start;
  logic [5:0]  shift_len;
  logic [39:0] shift_tx;
  logic        shift_ready;
  logic        shift_finish;
  logic [31:0] shift_rx;

  accel_spi_shift #(.SCLK_HALF(SCLK_HALF)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (shift_start),
    .len    (shift_len),
    .tx     (shift_tx),
    .miso   (spi_miso),
    .cs_n   (spi_cs_n),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .ready  (shift_ready),
    .finish (shift_finish),
    .rx     (shift_rx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      launched_q  <= 1'b0;
      init_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      rate_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      launched_q  <= launched_d;
      init_done_q <= init_done_d;
      overrun_q   <= overrun_d;
      rate_q      <= rate_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    launched_d  = launched_q;
    init_done_d = init_done_q;
    overrun_d   = overrun_q;
    x_d         = x_q;
    y_d         = y_q;
    rate_d      = '0;
    req         = 1'b0;
    if (init_done_q) begin
      req    = (rate_q == 32'(SAMPLE_DIV - 1));
      rate_d = req ? 32'd0 : rate_q + 32'd1;
    end

    shift_len = LEN_READ;
    shift_tx  = {CMD_READ_XY, 32'h0};
    case (state_q)
      ST_INIT_FMT: begin
        shift_len = LEN_WRITE;
        shift_tx  = {REG_DATA_FORMAT, DATA_FORMAT_VAL, 24'h0};
      end
      ST_INIT_PWR: begin
        shift_len = LEN_WRITE;
        shift_tx  = {REG_POWER_CTL, POWER_CTL_VAL, 24'h0};
      end
      default: ;
    endcase

    // Start is held until the shifter leaves its inter-transfer gap.
    shift_start = (state_q inside {ST_INIT_FMT, ST_INIT_PWR, ST_READ}) && !launched_q;
    if (shift_start && shift_ready) launched_d = 1'b1;

    case (state_q)
      ST_RESET: begin
`ifdef ACCEL_INIT_EN
        state_d = ST_INIT_FMT;
`else
        state_d     = ST_IDLE;
        init_done_d = 1'b1;
`endif
      end
      ST_INIT_FMT: begin
        if (launched_q && shift_finish) begin
          state_d    = ST_INIT_PWR;
          launched_d = 1'b0;
        end
      end
      ST_INIT_PWR: begin
        if (launched_q && shift_finish) begin
          state_d     = ST_IDLE;
          launched_d  = 1'b0;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_READ;
          launched_d = 1'b0;
        end
      end
      ST_READ: begin
        if (launched_q && shift_finish) begin
          state_d    = ST_DONE;
          launched_d = 1'b0;
          x_d        = sext16({shift_rx[23:16], shift_rx[31:24]});
          y_d        = sext16({shift_rx[7:0], shift_rx[15:8]});
        end
      end
      ST_DONE: begin
        state_d    = req ? ST_READ : ST_IDLE;
        launched_d = 1'b0;
      end
      default: state_d = ST_RESET;
    endcase

    if (req && !(state_q inside {ST_IDLE, ST_DONE})) overrun_d = 1'b1;
  end

  assign sample_tick = (state_q == ST_DONE);
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign overrun     = overrun_q;
  assign init_done   = init_done_q;
  assign busy        = !spi_cs_n || (state_q inside {ST_INIT_FMT, ST_INIT_PWR});

endmodule
